// File: rtl/cpu_pkg.sv
// Shared RV32 pipeline definitions: opcodes, ALU op encodings, the control
// bundle carried by the ID/EX, EX/MEM and MEM/WB registers, and opcode helpers.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } aluOp_e;

  typedef struct packed {
    logic       regWrite;
    logic       aluSrc;
    logic       branch;
    logic       memWrite;
    logic       memRead;
    logic       memToReg;
    logic [1:0] aluOp;
  } ctrl_t;

  function automatic logic isLegal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_IMM);
  endfunction

  function automatic logic usesRs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the
// destination of a load currently sitting in EX.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       exValid,
  input  logic       exMemRead,
  input  logic [4:0] exRd,
  input  logic [4:0] idRs1,
  input  logic [4:0] idRs2,
  input  logic [6:0] idOpcode,
  output logic       hazard
);

  logic rs1Hit;
  logic rs2Hit;

  // Illegal opcodes read nothing, so they can never stall the pipe.
  assign rs1Hit = isLegal(idOpcode) && (exRd == idRs1);
  assign rs2Hit = usesRs2(idOpcode) && (exRd == idRs2);
  assign hazard = exValid && exMemRead && (exRd != 5'd0) && (rs1Hit || rs2Hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with control sanitisation, flush squash, illegal
// opcode detection and (when HAZARD_DETECT_EN is defined) load-use stalling.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            RegWrite_i,
  input  logic            ALUSrc_i,
  input  logic            Branch_i,
  input  logic            MemWrite_i,
  input  logic            MemRead_i,
  input  logic            MemtoReg_i,
  input  logic [1:0]      ALU_op_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic [4:0]      rd_addr_o,
  output logic [3:0]      funct_o,
  output logic            RegWrite_o,
  output logic            ALUSrc_o,
  output logic            Branch_o,
  output logic            MemWrite_o,
  output logic            MemRead_o,
  output logic            MemtoReg_o,
  output logic [1:0]      ALU_op_o,
  output logic            illegal_o
);

  logic [6:0]      opcode;
  logic            legal;
  logic            hazard;
  logic            capture;
  logic            squashIllegal;
  logic            unusedInstrBits;
  ctrl_t           ctrlId;

  ctrl_t           ctrl_p1;
  logic            vld_p1;
  logic            illegal_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] rs1Data_p1;
  logic [XLEN-1:0] rs2Data_p1;
  logic [XLEN-1:0] imm_p1;
  logic [4:0]      rs1Addr_p1;
  logic [4:0]      rs2Addr_p1;
  logic [4:0]      rdAddr_p1;
  logic [3:0]      funct_p1;

  assign opcode          = instr_i[6:0];
  assign legal           = isLegal(opcode);
  assign unusedInstrBits = ^{instr_i[31], instr_i[29:25]};

`ifdef HAZARD_DETECT_EN
  hazard_detect uHazard (
    .exValid   (vld_p1),
    .exMemRead (ctrl_p1.memRead),
    .exRd      (rdAddr_p1),
    .idRs1     (instr_i[19:15]),
    .idRs2     (instr_i[24:20]),
    .idOpcode  (opcode),
    .hazard    (hazard)
  );
`else
  assign hazard = 1'b0;
`endif

  assign stall_o       = hazard & ~flush_i;
  assign capture       = ~flush_i & ~hazard & legal;
  assign squashIllegal = ~flush_i & ~hazard & ~legal;

  // Memory enables are tied to the opcode so decoder don't-cares never leak into EX.
  always_comb begin
    ctrlId          = '0;
    ctrlId.regWrite = RegWrite_i;
    ctrlId.aluSrc   = ALUSrc_i;
    ctrlId.branch   = Branch_i;
    ctrlId.memWrite = MemWrite_i & (opcode == OP_STORE);
    ctrlId.memRead  = MemRead_i & (opcode == OP_LOAD);
    ctrlId.memToReg = MemtoReg_i;
    ctrlId.aluOp    = ALU_op_i;
  end

  // ID -> EX boundary: a bubble zeroes control and datapath alike.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      ctrl_p1    <= '0;
      pc_p1      <= '0;
      rs1Data_p1 <= '0;
      rs2Data_p1 <= '0;
      imm_p1     <= '0;
      rs1Addr_p1 <= '0;
      rs2Addr_p1 <= '0;
      rdAddr_p1  <= '0;
      funct_p1   <= '0;
    end else begin
      vld_p1     <= capture;
      illegal_p1 <= squashIllegal;
      ctrl_p1    <= capture ? ctrlId : '0;
      pc_p1      <= capture ? pc_i : '0;
      rs1Data_p1 <= capture ? rs1_data_i : '0;
      rs2Data_p1 <= capture ? rs2_data_i : '0;
      imm_p1     <= capture ? imm_i : '0;
      rs1Addr_p1 <= capture ? instr_i[19:15] : 5'd0;
      rs2Addr_p1 <= capture ? instr_i[24:20] : 5'd0;
      rdAddr_p1  <= capture ? instr_i[11:7] : 5'd0;
      funct_p1   <= capture ? {instr_i[30], instr_i[14:12]} : 4'd0;
    end
  end

  assign valid_o    = vld_p1;
  assign illegal_o  = illegal_p1;
  assign pc_o       = pc_p1;
  assign rs1_data_o = rs1Data_p1;
  assign rs2_data_o = rs2Data_p1;
  assign imm_o      = imm_p1;
  assign rs1_addr_o = rs1Addr_p1;
  assign rs2_addr_o = rs2Addr_p1;
  assign rd_addr_o  = rdAddr_p1;
  assign funct_o    = funct_p1;
  assign RegWrite_o = ctrl_p1.regWrite;
  assign ALUSrc_o   = ctrl_p1.aluSrc;
  assign Branch_o   = ctrl_p1.branch;
  assign MemWrite_o = ctrl_p1.memWrite;
  assign MemRead_o  = ctrl_p1.memRead;
  assign MemtoReg_o = ctrl_p1.memToReg;
  assign ALU_op_o   = ctrl_p1.aluOp;

endmodule
